addsub_serial: RTL and testbench
================================

# addsub_serial

Parametrised multi-cycle adder/subtractor. Computes A+B or A−B on WIDTH-bit operands, CHUNK bits per clock, and reports carry, signed overflow and zero flags. A start/busy/done handshake brackets each operation. It sits in the adder library as the sequential, area-reduced successor to the fixed 16-bit combinational half adder: full B operand instead of a 1-bit increment, an add/subtract mode, and configurable width and slice size.

## Interface
Parameters:
- WIDTH, 16, operand and result width; must be a positive multiple of CHUNK.
- CHUNK, 4, bits processed per cycle. N = WIDTH/CHUNK cycles per operation.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- start, input, 1, request; sampled only when busy=0.
- sub, input, 1, mode: 0 = A+B, 1 = A−B; sampled with start.
- a, input, WIDTH, operand A; sampled with start.
- b, input, WIDTH, operand B; sampled with start.
- busy, output, 1, operation in progress.
- done, output, 1, one-cycle pulse; result and flags valid.
- s, output, WIDTH, result.
- c, output, 1, carry out. For subtraction this is the no-borrow flag: 1 when a ≥ b unsigned.
- v, output, 1, two's-complement overflow.
- z, output, 1, result equals zero.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1:
  - Latch a into operand register A.
  - Latch b into operand register B. When sub=1, latch ~b instead.
  - Load the carry register with sub.
  - Clear the chunk counter and go to RUN.
- RUN, each cycle:
  - Add the low CHUNK bits of A and B plus carry.
  - Shift the CHUNK-bit sum into the top of the result register from the MSB side, so that after N cycles the first chunk sits at the LSB.
  - Shift A and B right by CHUNK.
  - Update the carry register and increment the counter.
- Last RUN cycle (counter = N−1):
  - Capture the final carry into c.
  - Compute v = (signA == signB') && (signS != signA). signA, signB' and signS are the MSBs of a, of the effective second operand (b or ~b) and of the result. Store the operand sign bits at start for this purpose.
  - Compute z from the full result.
  - Go to DONE.
- DONE lasts one cycle, then returns to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, which allows back-to-back operations.
- start while busy=1 is ignored. a, b and sub may change freely during RUN without effect.
- s, c, v and z hold their last values until the next operation completes. They are not updated mid-operation.
- Arithmetic is modulo 2^WIDTH. Wrap-around is reported only through c and v.

## Timing
- Reset (rst_n=0, at any time, including mid-RUN): state=IDLE, busy=0, done=0, s=0, c=0, v=0, z=0, internal registers cleared. Any in-flight operation is abandoned and no done is produced.
- start sampled high at edge k:
  - busy=1 after edge k, through edge k+N.
  - done=1 for exactly the cycle after edge k+N.
  - s, c, v and z update at edge k+N.
  - busy=0 while done=1.
- Latency start→done = N+1 cycles (5 for the defaults).
- Back-to-back throughput: one result every N+1 cycles.
- busy = (state==RUN). done = (state==DONE). Both are registered decodes with no combinational path from inputs.

## Test plan
- Reset, then add 0xFFFF + 0x0001 → done 5 cycles after start; s=0x0000, c=1, v=0, z=1.
- Add 0x7FFF + 0x0001 → s=0x8000, c=0, v=1, z=0. Add 0x1234 + 0x4321 → s=0x5555, c=0, v=0.
- Subtract 5 − 3 → s=0x0002, c=1, v=0. Subtract 3 − 5 → s=0xFFFE, c=0, v=0. Subtract 0x8000 − 1 → s=0x7FFF, v=1.
- Hold start=1 continuously with changing a/b:
  - Only operations launched in IDLE/DONE are performed.
  - Mid-RUN changes are ignored.
  - done pulses every 5 cycles.
- Drop rst_n for one cycle during RUN (cycle 2 of 4) → busy, done, s, c, v, z all 0 immediately. No done pulse follows. The next start completes normally.
- Re-run 0xFFFF+1 and 0x7FFF+1 with WIDTH=8/CHUNK=2 and WIDTH=32/CHUNK=8 at the equivalent boundary values → same flag results. Latency = WIDTH/CHUNK + 1.

Source files
------------

// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle adder/subtractor that handles CHUNK bits per
// clock over WIDTH-bit operands. It reports carry (no-borrow on subtract),
// signed overflow and zero flags, using a start/busy/done handshake.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg;
  logic [WIDTH-1:0] acc_shift;
  logic [CNT_W-1:0] cnt_reg;
  logic             carry_reg;
  logic             sign_a_reg, sign_b_reg;
  logic [WIDTH-1:0] s_reg;
  logic             c_reg, v_reg, z_reg;
  logic [CHUNK:0]   chunk_sum;
  logic             load, last;

  // One slice of the ripple: low chunk of each operand plus the running carry
  assign chunk_sum = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_reg};

  // New slice enters at the MSB end; after N slices the first one is at the LSB
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign acc_shift = chunk_sum[CHUNK-1:0];
    end else begin : g_multi
      assign acc_shift = {chunk_sum[CHUNK-1:0], acc_reg[WIDTH-1:CHUNK]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; DONE accepts start just like IDLE for back-to-back use
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-cycle slice processing and result/flag update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      s_reg      <= '0;
      c_reg      <= 1'b0;
      v_reg      <= 1'b0;
      z_reg      <= 1'b0;
    end else begin
      if (load) begin
        // Subtraction is a + ~b + 1: invert b and seed the carry with 1
        a_reg      <= a;
        b_reg      <= sub ? ~b : b;
        carry_reg  <= sub;
        cnt_reg    <= '0;
        sign_a_reg <= a[WIDTH-1];
        sign_b_reg <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
      end else if (state_reg == RUN) begin
        a_reg     <= a_reg >> CHUNK;
        b_reg     <= b_reg >> CHUNK;
        carry_reg <= chunk_sum[CHUNK];
        acc_reg   <= acc_shift;
        cnt_reg   <= cnt_reg + CNT_W'(1);
      end
      if (last) begin
        s_reg <= acc_shift;
        c_reg <= chunk_sum[CHUNK];
        v_reg <= (sign_a_reg == sign_b_reg) && (acc_shift[WIDTH-1] != sign_a_reg);
        z_reg <= (acc_shift == '0);
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign s    = s_reg;
  assign c    = c_reg;
  assign v    = v_reg;
  assign z    = z_reg;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three configurations (16/4, 8/2, 32/8) checked
// against an integer-arithmetic reference model.
module tb_addsub_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic        sub_in = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

  logic        busy0, done0, c0, v0, z0;
  logic [15:0] s0;
  logic        busy1, done1, c1, v1, z1;
  logic [7:0]  s1;
  logic        busy2, done2, c2, v2, z2;
  logic [31:0] s2;

  int errors = 0;
  int checks = 0;
  int sel = 0;

  logic        obs_busy, obs_done, obs_c, obs_v, obs_z;
  logic [31:0] obs_s;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub_in),
    .a(a_in[15:0]), .b(b_in[15:0]), .busy(busy0), .done(done0),
    .s(s0), .c(c0), .v(v0), .z(z0));

  addsub_serial #(.WIDTH(8), .CHUNK(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub_in),
    .a(a_in[7:0]), .b(b_in[7:0]), .busy(busy1), .done(done1),
    .s(s1), .c(c1), .v(v1), .z(z1));

  addsub_serial #(.WIDTH(32), .CHUNK(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub_in),
    .a(a_in), .b(b_in), .busy(busy2), .done(done2),
    .s(s2), .c(c2), .v(v2), .z(z2));

  // Select the instance currently being observed
  always_comb begin
    obs_busy = busy0; obs_done = done0; obs_s = {16'h0, s0};
    obs_c = c0; obs_v = v0; obs_z = z0;
    case (sel)
      1: begin
        obs_busy = busy1; obs_done = done1; obs_s = {24'h0, s1};
        obs_c = c1; obs_v = v1; obs_z = z1;
      end
      2: begin
        obs_busy = busy2; obs_done = done2; obs_s = s2;
        obs_c = c2; obs_v = v2; obs_z = z2;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, modulo 2^w, with signed range test
  function automatic void model(input int w, input logic sb, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] es,
                                output logic ec, output logic ev, output logic ez);
    longint m, half, ua, ub, sa, sv, r, full;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sv   = (ub >= half) ? ub - (m + 1) : ub;
    if (!sb) begin
      full = ua + ub;
      ec   = (full > m);
      es   = 32'(full & m);
      r    = sa + sv;
    end else begin
      es   = 32'((ua - ub) & m);
      ec   = (ua >= ub);
      r    = sa - sv;
    end
    ev = (r > half - 1) || (r < -half);
    ez = (es == 32'h0);
  endfunction

  function automatic int width_of(input int inst);
    return (inst == 0) ? 16 : (inst == 1) ? 8 : 32;
  endfunction

  function automatic int n_of(input int inst);
    return (inst == 0) ? 4 : (inst == 1) ? 4 : 4;
  endfunction

  task automatic set_start(input int inst, input logic val);
    case (inst)
      0: start0 = val;
      1: start1 = val;
      default: start2 = val;
    endcase
  endtask

  // One operation: launch, scramble inputs during RUN, wait for done, check all
  task automatic run_op(input int inst, input logic sb, input logic [31:0] a, input logic [31:0] b);
    int w, n, lat;
    logic seen;
    logic [31:0] es;
    logic ec, ev, ez;
    w = width_of(inst);
    n = n_of(inst);
    sel = inst;
    model(w, sb, a, b, es, ec, ev, ez);
    @(negedge clk);
    a_in = a; b_in = b; sub_in = sb;
    set_start(inst, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(inst, 1'b0);
    a_in = $urandom; b_in = $urandom; sub_in = ~sb;
    check($sformatf("busy_run i%0d", inst), {31'h0, obs_busy}, 32'd1);
    lat = 1;
    seen = obs_done;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      seen = obs_done;
    end
    check($sformatf("done_seen i%0d", inst), {31'h0, seen}, 32'd1);
    if (seen) begin
      check($sformatf("latency i%0d", inst), 32'(lat), 32'(n + 1));
      check($sformatf("busy_at_done i%0d", inst), {31'h0, obs_busy}, 32'd0);
      check($sformatf("s i%0d %h%s%h", inst, a, sb ? "-" : "+", b), obs_s, es);
      check($sformatf("c i%0d %h%s%h", inst, a, sb ? "-" : "+", b), {31'h0, obs_c}, {31'h0, ec});
      check($sformatf("v i%0d %h%s%h", inst, a, sb ? "-" : "+", b), {31'h0, obs_v}, {31'h0, ev});
      check($sformatf("z i%0d %h%s%h", inst, a, sb ? "-" : "+", b), {31'h0, obs_z}, {31'h0, ez});
      $display("op i%0d a=%h b=%h sub=%0d -> s=%h c=%0d v=%0d z=%0d lat=%0d",
               inst, a, b, sb, obs_s, obs_c, obs_v, obs_z, lat);
      @(negedge clk);
      check($sformatf("done_pulse_once i%0d", inst), {31'h0, obs_done}, 32'd0);
    end
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    logic [31:0] r;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 5))
      0: r = 32'h0;
      1: r = m;
      2: r = (32'd1 << (w - 1));
      3: r = (32'd1 << (w - 1)) - 32'd1;
      default: r = $urandom;
    endcase
    return r & m;
  endfunction

  logic [31:0] la [0:24];
  logic [31:0] lb [0:24];
  logic        ls [0:24];

  initial begin
    logic [31:0] es;
    logic ec, ev, ez, any_done;

    // Reset state for every configuration
    #12;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check($sformatf("rst busy i%0d", i), {31'h0, obs_busy}, 32'd0);
      check($sformatf("rst done i%0d", i), {31'h0, obs_done}, 32'd0);
      check($sformatf("rst s i%0d", i), obs_s, 32'd0);
      check($sformatf("rst cvz i%0d", i), {29'h0, obs_c, obs_v, obs_z}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases on the 16-bit instance
    run_op(0, 1'b0, 32'hFFFF, 32'h0001);
    run_op(0, 1'b0, 32'h7FFF, 32'h0001);
    run_op(0, 1'b0, 32'h1234, 32'h4321);
    run_op(0, 1'b1, 32'h0005, 32'h0003);
    run_op(0, 1'b1, 32'h0003, 32'h0005);
    run_op(0, 1'b1, 32'h8000, 32'h0001);

    // Equivalent boundary values on the narrow and wide instances
    run_op(1, 1'b0, 32'hFF, 32'h01);
    run_op(1, 1'b0, 32'h7F, 32'h01);
    run_op(1, 1'b1, 32'h80, 32'h01);
    run_op(2, 1'b0, 32'hFFFF_FFFF, 32'h1);
    run_op(2, 1'b0, 32'h7FFF_FFFF, 32'h1);
    run_op(2, 1'b1, 32'h8000_0000, 32'h1);

    // Randomised operations on every instance
    for (int inst = 0; inst < 3; inst++) begin
      for (int k = 0; k < 12; k++) begin
        run_op(inst, 1'($urandom_range(0, 1)), pick(width_of(inst)), pick(width_of(inst)));
      end
    end

    // start held high: launches only at edges 0,5,10,... with per-cycle input churn
    sel = 0;
    @(negedge clk);
    a_in = $urandom; b_in = $urandom; sub_in = 1'($urandom_range(0, 1));
    start0 = 1'b1;
    for (int j = 0; j < 25; j++) begin
      @(posedge clk);
      la[j] = a_in; lb[j] = b_in; ls[j] = sub_in;
      @(negedge clk);
      check($sformatf("held done j%0d", j), {31'h0, obs_done}, {31'h0, (j % 5) == 4});
      check($sformatf("held busy j%0d", j), {31'h0, obs_busy}, {31'h0, (j % 5) != 4});
      if ((j % 5) == 4) begin
        model(16, ls[j-4], la[j-4], lb[j-4], es, ec, ev, ez);
        check($sformatf("held s j%0d", j), obs_s, es);
        check($sformatf("held cvz j%0d", j), {29'h0, obs_c, obs_v, obs_z}, {29'h0, ec, ev, ez});
        $display("held op j%0d a=%h b=%h sub=%0d -> s=%h", j, la[j-4][15:0], lb[j-4][15:0], ls[j-4], obs_s);
      end
      a_in = $urandom; b_in = $urandom; sub_in = 1'($urandom_range(0, 1));
    end
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of RUN abandons the operation
    run_op(0, 1'b0, 32'h1234, 32'h4321);
    @(negedge clk);
    a_in = 32'h1111; b_in = 32'h2222; sub_in = 1'b0;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun rst busy", {31'h0, obs_busy}, 32'd0);
    check("midrun rst done", {31'h0, obs_done}, 32'd0);
    check("midrun rst s", obs_s, 32'd0);
    check("midrun rst cvz", {29'h0, obs_c, obs_v, obs_z}, 32'd0);
    $display("mid-run reset applied");
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      any_done = any_done | obs_done;
    end
    check("no done after rst", {31'h0, any_done}, 32'd0);
    run_op(0, 1'b0, 32'h0F0F, 32'h0101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
